// File: rtl/aes_pkg.sv
// Shared definitions for the AES key expander: key-length encodings, schedule
// geometry lookups, GF(2^8) xtime, FSM state type and the forward S-box.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEY    = 2'd1,
        ST_EXPAND = 2'd2,
        ST_FIN    = 2'd3
    } state_e;

    function automatic logic [3:0] get_nk(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [5:0] get_total_words(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd52;
            KL_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key schedule generator over a valid/ready stream.
// Optional schedule RAM with a read port is enabled by defining AES_KEXP_STORE_EN.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter bit SUPPORT_256 = 1'b1,
    parameter bit OUT_REG     = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [31:0]  word_out,
    output logic [5:0]   word_index,
    output logic         busy,
`ifdef AES_KEXP_STORE_EN
    input  logic [5:0]   rd_addr,
    output logic [31:0]  rd_data,
`endif
    output logic         done
);

    state_e        state_q, state_d;
    logic [1:0]    kl_q, kl_d, kl_sel;
    logic [255:0]  key_q, key_d;
    logic [5:0]    idx_q, idx_d;
    logic [2:0]    pos_q, pos_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [31:0]   win_q [8];

    logic [3:0]    nk;
    logic [2:0]    nk_m1;
    logic [5:0]    total;
    logic [5:0]    nxt_idx;
    logic [31:0]   key_words [8];
    logic [31:0]   prev_word, sub_in, sub_out, t_word, nxt_word;
    logic          accept, shift_en;
    logic [31:0]   shift_word;

    // Unsupported and reserved encodings collapse onto AES-128.
    always_comb begin
        case (key_len)
            KL_192:  kl_sel = KL_192;
            KL_256:  kl_sel = SUPPORT_256 ? KL_256 : KL_128;
            default: kl_sel = KL_128;
        endcase
    end

    assign nk      = get_nk(kl_q);
    assign nk_m1   = 3'(nk - 4'd1);
    assign total   = get_total_words(kl_q);
    assign nxt_idx = idx_q + 6'd1;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            key_words[k] = key_q[255 - 32*k -: 32];
        end
    end

    // win_q[0] is the word currently presented, so win_q[Nk-1] is w[next-Nk].
    assign prev_word = win_q[0];
    assign sub_in    = (pos_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        t_word = prev_word;
        if (pos_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h0};
        end else if (nk == 4'd8 && pos_q == 3'd4) begin
            t_word = sub_out;
        end
        nxt_word = (nxt_idx < {2'b00, nk}) ? key_words[nxt_idx[2:0]] : (win_q[nk_m1] ^ t_word);
    end

    assign word_valid = (state_q == ST_KEY) || (state_q == ST_EXPAND);
    assign busy       = word_valid;
    assign done       = (state_q == ST_FIN);
    assign accept     = word_valid && word_ready;

    always_comb begin
        state_d    = state_q;
        kl_d       = kl_q;
        key_d      = key_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        rcon_d     = rcon_q;
        shift_en   = 1'b0;
        shift_word = nxt_word;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_KEY;
                    kl_d       = kl_sel;
                    key_d      = key_in;
                    idx_d      = 6'd0;
                    pos_d      = 3'd1;
                    rcon_d     = 8'h01;
                    shift_en   = 1'b1;
                    shift_word = key_in[255:224];
                end
            end
            ST_KEY, ST_EXPAND: begin
                if (accept) begin
                    if (idx_q == total - 6'd1) begin
                        state_d = ST_FIN;
                    end else begin
                        shift_en = 1'b1;
                        idx_d    = nxt_idx;
                        pos_d    = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
                        if (pos_q == 3'd0) rcon_d = xtime(rcon_q);
                        if (nxt_idx >= {2'b00, nk}) state_d = ST_EXPAND;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            kl_q    <= KL_128;
            key_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            kl_q    <= kl_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
        end else if (shift_en) begin
            for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
            win_q[0] <= shift_word;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [31:0] out_q;
            logic [5:0]  oidx_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_q  <= '0;
                    oidx_q <= '0;
                end else if (shift_en) begin
                    out_q  <= shift_word;
                    oidx_q <= idx_d;
                end
            end
            assign word_out   = out_q;
            assign word_index = oidx_q;
        end else begin : g_out_comb
            assign word_out   = win_q[0];
            assign word_index = idx_q;
        end
    endgenerate

`ifdef AES_KEXP_STORE_EN
    logic [31:0] sched_mem [60];
    logic [31:0] rd_data_q;

    // NOTE: the schedule RAM is deliberately not reset; it maps onto plain RAM and stale words stay readable.
    always_ff @(posedge clock) begin
        if (accept) sched_mem[idx_q] <= win_q[0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= (rd_addr < total) ? sched_mem[rd_addr] : '0;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Parametrised successor to the fixed AES-128 word-serial key expansion. Supports AES-128, AES-192 and AES-256, with the key length selected per job at runtime. Emits the full round-key schedule w[0..Nr*4+3] one 32-bit word per cycle over a valid/ready stream. Sits between the key-load interface and the round datapath (cipher and inverse-cipher cores).

Parameters:
SUPPORT_256, 1, 0 limits the block to 128/192 (key_len 2'b10 is then treated as 2'b00); 1 enables 256.
OUT_REG, 1, 1 registers word_out/word_index; 0 drives them combinationally from the window (same valid timing).

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
key_len  in  2  00=128, 01=192, 10=256, 11=reserved (treated as 00)
key_in  in  256  key MSB-aligned: a 128-bit key is in [255:128], a 192-bit key in [255:64]; w[0]=key_in[255:224]
word_valid  out  1  word_out holds a valid schedule word
word_ready  in  1  consumer accepts the word when valid & ready
word_out  out  32  schedule word w[i]
word_index  out  6  i, 0..59
busy  out  1  high from start acceptance until the last word is accepted
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Nk=4/6/8 and total words 44/52/60 are selected by key_len, latched at start. key_in is latched at start; later changes are ignored.
- Reset values: word_valid=0, word_out=0, word_index=0, busy=0, done=0, FSM=IDLE, Rcon register=8'h01.
- FSM states: IDLE, KEY, EXPAND, FIN.
  - IDLE: on start, go to KEY and set busy=1. start while busy is ignored.
  - KEY: emits w[0..Nk-1] straight from the latched key.
  - EXPAND: emits w[Nk..total-1].
  - FIN: pulses done for one cycle, clears busy, returns to IDLE.
- Latency: start accepted at edge N gives word_valid=1 with w[0] at edge N+1. With word_ready tied high, one word per cycle and no bubbles. The last word (w[43], w[51] or w[59]) appears at edge N+44, N+52 or N+60. done pulses the cycle after the last acceptance.
- Backpressure: while word_valid & !word_ready, word_out and word_index hold stable and no internal state advances.
- Recurrence: w[i] = w[i-Nk] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i mod Nk == 0;
  - t = SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4;
  - otherwise t = w[i-1].
- Storage: an 8-word shift window holds w[i-8..i-1]; the Nk-dependent tap selects w[i-Nk].
- Position counter: a mod-Nk counter that wraps from Nk-1 to 0.
- Rcon: a register initialised to 01 at start, advanced by xtime (shift left; XOR 1b on carry-out) after each i mod Nk == 0 word. The sequence is 01,02,…,80,1b,36; no table.
- Boundaries:
  - Reset asserted mid-job aborts immediately: all outputs go to reset values and no done pulse is produced.
  - A start arriving in the same cycle as done is ignored; a new job starts only from IDLE.
  - word_index saturates at total-1 and never wraps within a job.

Optional Feature:
AES_KEXP_STORE_EN
- With the macro: adds a 60x32 schedule RAM written as each word is accepted, plus ports rd_addr[5:0] in and rd_data[31:0] out.
  - Read latency is 1 cycle; this serves inverse-cipher reverse-order access.
  - Addresses at or above total words return 0.
  - Reads during a job return the old contents for addresses not yet written.
- Without the macro: these ports and the RAM do not exist; the block is stream-only.

Decomposition:
- Package aes_pkg holds:
  - key_len encodings KL_128/KL_192/KL_256;
  - NK and TOTAL_WORDS lookup functions;
  - the xtime function;
  - the FSM state typedef;
  - the S-box constant array.
- One natural sub-module: aes_subword, purely combinational, mapping 32 bits to 32 bits through four S-box lookups. It is shared by both the i mod Nk == 0 path and the i mod Nk == 4 path; only one is active per cycle.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6; 44 words; done at start+45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202; 52 words.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord path at i mod 8 == 4), w[59]=706c631e.
- AES-128 with random word_ready (~50%) -> the word sequence is identical to the ready=1 run; word_out is stable while stalled; no words are dropped or duplicated.
- Reset pulse at word 20 of an AES-256 job -> outputs zero with no done pulse; a following AES-128 start produces a correct, complete schedule.
- start held high for the whole job plus key_len=11 -> only one job runs, treated as AES-128; the second start is accepted only after returning to IDLE.
